// File: rtl/cpc_memory_sequencer_if.sv
// Z80 bus seen by the CPC memory sequencer: address/control/data from the CPU,
// WAIT back to the CPU.
interface cpc_memory_sequencer_if;
  logic [15:0] cpu_addr;
  logic        mreq_n;
  logic        iorq_n;
  logic        rd_n;
  logic        wr_n;
  logic [7:0]  data_from_cpu;
  logic        wait_n;

  modport master (
    output cpu_addr, mreq_n, iorq_n, rd_n, wr_n, data_from_cpu,
    input  wait_n
  );

  modport slave (
    input  cpu_addr, mreq_n, iorq_n, rd_n, wr_n, data_from_cpu,
    output wait_n
  );
endinterface

// File: rtl/cpc_memory_sequencer.sv
// Gate-array memory timing generator: splits each 16-clk period into video and
// CPU RAM slots, inserts Z80 wait states, and holds the ROM-enable bits.
module cpc_memory_sequencer #(
  parameter bit VIDEO_FIRST = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  cpc_memory_sequencer_if.slave         cpu,
  output logic                          cpu_clk_en,
  output logic                          crtc_clk_en,
  output logic                          cpu_n,
  output logic                          ras_n,
  output logic                          cas_n,
  output logic                          mwe_n,
  output logic                          ready,
  output logic                          romen_n,
  output logic                          ramrd_n,
  output logic                          en244_n,
  output logic                          lower_rom_en,
  output logic                          upper_rom_en
);

  localparam logic [3:0] CPU_BASE   = VIDEO_FIRST ? 4'd8 : 4'd0;
  localparam logic [3:0] CPU_LAST   = CPU_BASE + 4'd7;
  localparam logic [3:0] VIDEO_BASE = CPU_BASE ^ 4'd8;

  logic [3:0] phase;
  logic [3:0] phase_nx;
  logic [2:0] o_nx;
  logic       cpu_slot_nx;
  logic       row_nx;
  logic       col_nx;

  logic acc_valid;
  logic acc_wr;
  logic served;
  logic mem_req;
  logic mem_rd;
  logic rom_win;
  logic ga_sel;
  logic ga_sel_q;
  logic unused_bus;

  // Strobes are registered from the upcoming phase so each value lines up
  // with the clk in which phase equals the slot position it describes.
  assign phase_nx    = phase + 4'd1;
  assign o_nx        = phase_nx[2:0];
  assign cpu_slot_nx = (phase_nx[3] == VIDEO_FIRST);
  assign row_nx      = (o_nx != 3'd0) && (o_nx != 3'd7);
  assign col_nx      = (o_nx >= 3'd3) && (o_nx <= 3'd6);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase       <= '0;
      cpu_clk_en  <= 1'b0;
      crtc_clk_en <= 1'b0;
      cpu_n       <= 1'b1;
      ras_n       <= 1'b1;
      cas_n       <= 1'b1;
      mwe_n       <= 1'b1;
      ready       <= 1'b0;
    end else begin
      phase       <= phase_nx;
      cpu_clk_en  <= (phase_nx[1:0] == 2'b11);
      crtc_clk_en <= (phase_nx == 4'hF);
      cpu_n       <= !cpu_slot_nx;
      ras_n       <= !row_nx;
      cas_n       <= !col_nx;
      mwe_n       <= !(cpu_slot_nx && col_nx && acc_valid && acc_wr);
      ready       <= (phase_nx == CPU_LAST);
    end
  end

  // A simultaneous IORQ+MREQ is not a memory access.
  assign mem_req = !cpu.mreq_n && cpu.iorq_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_valid <= 1'b0;
      acc_wr    <= 1'b0;
      served    <= 1'b0;
    end else begin
      if (phase == CPU_BASE) begin
        acc_valid <= mem_req;
        acc_wr    <= !cpu.wr_n;
      end else if (phase_nx == VIDEO_BASE) begin
        acc_valid <= 1'b0;
      end
      if (!mem_req) begin
        served <= 1'b0;
      end else if (phase_nx == CPU_LAST && acc_valid) begin
        served <= 1'b1;
      end
    end
  end

  assign mem_rd  = mem_req && !cpu.rd_n;
  assign rom_win = ((cpu.cpu_addr[15:14] == 2'b00) && lower_rom_en) ||
                   ((cpu.cpu_addr[15:14] == 2'b11) && upper_rom_en);
  assign ga_sel  = !cpu.iorq_n && !cpu.wr_n && cpu.mreq_n &&
                   (cpu.cpu_addr[15:14] == 2'b01);

  assign romen_n    = !(reset_n && mem_rd && rom_win);
  assign ramrd_n    = !(reset_n && mem_rd && !rom_win);
  assign en244_n    = !(reset_n && ga_sel);
  assign cpu.wait_n = !reset_n || !mem_req || served;

  // Register write fires once, on the first clk of the I/O write cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ga_sel_q     <= 1'b0;
      lower_rom_en <= 1'b1;
      upper_rom_en <= 1'b1;
    end else begin
      ga_sel_q <= ga_sel;
      if (ga_sel && !ga_sel_q && (cpu.data_from_cpu[7:6] == 2'b10)) begin
        lower_rom_en <= !cpu.data_from_cpu[2];
        upper_rom_en <= !cpu.data_from_cpu[3];
      end
    end
  end

  assign unused_bus = ^{cpu.cpu_addr[13:0], cpu.data_from_cpu[5:4],
                        cpu.data_from_cpu[1:0]};

endmodule

// File: tb/tb_cpc_memory_sequencer.sv
// Scoreboard bench for cpc_memory_sequencer: stimulus queues per-cycle expected
// output vectors, a negedge monitor pops and compares them.
module tb_cpc_memory_sequencer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  cpc_memory_sequencer_if bus();

  logic cpu_clk_en, crtc_clk_en, cpu_n, ras_n, cas_n, mwe_n, ready;
  logic romen_n, ramrd_n, en244_n, lower_rom_en, upper_rom_en;

  cpc_memory_sequencer #(.VIDEO_FIRST(1'b1)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cpu          (bus),
    .cpu_clk_en   (cpu_clk_en),
    .crtc_clk_en  (crtc_clk_en),
    .cpu_n        (cpu_n),
    .ras_n        (ras_n),
    .cas_n        (cas_n),
    .mwe_n        (mwe_n),
    .ready        (ready),
    .romen_n      (romen_n),
    .ramrd_n      (ramrd_n),
    .en244_n      (en244_n),
    .lower_rom_en (lower_rom_en),
    .upper_rom_en (upper_rom_en)
  );

  // Vector order: cce crtc wait cpu_n ras cas mwe ready romen ramrd en244 lo up
  localparam logic [12:0] ALL       = '1;
  localparam logic [12:0] NO_WAIT   = 13'b1101111111111;
  localparam logic [12:0] RESET_VAL = 13'b0011111011111;
  // Per-phase tables, bit n = phase n.
  localparam logic [15:0] CCE_M   = 16'h8888;
  localparam logic [15:0] CRTC_M  = 16'h8000;
  localparam logic [15:0] CPU_LOW = 16'hFF00;
  localparam logic [15:0] RAS_LOW = 16'h7E7E;
  localparam logic [15:0] CAS_LOW = 16'h7878;
  localparam logic [15:0] RDY_M   = 16'h8000;

  typedef struct {
    int          cyc;
    string       name;
    logic [12:0] mask;
    logic [12:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   cyc = 0;
  int   nchk = 0;
  int   nfail = 0;

  logic [12:0] obs;
  assign obs = {cpu_clk_en, crtc_clk_en, bus.wait_n, cpu_n, ras_n, cas_n, mwe_n,
                ready, romen_n, ramrd_n, en244_n, lower_rom_en, upper_rom_en};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      cur = sb.pop_front();
      nchk++;
      if (cur.cyc != cyc || ((obs ^ cur.val) & cur.mask) != '0) begin
        nfail++;
        $display("FAIL %s cyc=%0d got=%b want=%b mask=%b", cur.name, cyc, obs,
                 cur.val, cur.mask);
      end
    end
  end

  int   tph = 0;
  logic lo_e = 1'b1, up_e = 1'b1;
  logic e_wait, e_mwe, e_rom, e_ramrd, e_e244;

  task automatic step();
    @(posedge clk);
    #1;
    tph = (tph + 1) % 16;
  endtask

  task automatic push_raw(input string nm, input logic [12:0] m, input logic [12:0] v);
    sb.push_back('{cyc, nm, m, v});
  endtask

  task automatic push(input string nm, input logic [12:0] m);
    logic [12:0] v;
    v = {CCE_M[tph], CRTC_M[tph], e_wait, ~CPU_LOW[tph], ~RAS_LOW[tph],
         ~CAS_LOW[tph], e_mwe, RDY_M[tph], e_rom, e_ramrd, e_e244, lo_e, up_e};
    push_raw(nm, m, v);
  endtask

  task automatic idle_bus();
    bus.cpu_addr = 16'h0000; bus.mreq_n = 1'b1; bus.iorq_n = 1'b1;
    bus.rd_n = 1'b1; bus.wr_n = 1'b1; bus.data_from_cpu = 8'h00;
    e_wait = 1'b1; e_mwe = 1'b1; e_rom = 1'b1; e_ramrd = 1'b1; e_e244 = 1'b1;
  endtask

  task automatic cycles(input int n, input string nm);
    for (int i = 0; i < n; i++) begin step(); push(nm, ALL); end
  endtask

  // Run checked cycles until the next step() lands on phase p.
  task automatic wait_for(input int p);
    while ((tph + 1) % 16 != p) begin step(); push("idle", ALL); end
  endtask

  task automatic peek(input logic [15:0] a, input logic is_rom, input string nm);
    wait_for(1);
    step();
    bus.cpu_addr = a; bus.mreq_n = 1'b0; bus.rd_n = 1'b0;
    e_wait = 1'b0; e_rom = !is_rom; e_ramrd = is_rom;
    push(nm, ALL);
    step(); push(nm, ALL);
    step(); idle_bus(); push("peek_end", ALL);
  endtask

  task automatic ga_write(input logic [7:0] d, input logic nlo, input logic nup,
                          input string nm);
    wait_for(2);
    step();
    bus.cpu_addr = 16'h7F00; bus.iorq_n = 1'b0; bus.wr_n = 1'b0; bus.data_from_cpu = d;
    e_e244 = 1'b0;
    push({nm, "_first"}, ALL);
    step(); lo_e = nlo; up_e = nup; push(nm, ALL);
    step(); push(nm, ALL);
    step(); idle_bus(); push("ga_end", ALL);
  endtask

  initial begin
    idle_bus();
    reset_n = 1'b0;
    bus.cpu_addr = 16'h0000; bus.mreq_n = 1'b0; bus.rd_n = 1'b0;
    repeat (3) begin step(); push_raw("reset", ALL, RESET_VAL); end

    step(); idle_bus(); reset_n = 1'b1; tph = 0;
    push("timing", ALL);
    cycles(31, "timing");

    // RAM read arriving before the CPU-slot sample
    wait_for(5);
    step();
    bus.cpu_addr = 16'h4000; bus.mreq_n = 1'b0; bus.rd_n = 1'b0;
    e_wait = 1'b0; e_ramrd = 1'b0;
    push("ram_read", ALL);
    cycles(9, "ram_wait");
    step(); e_wait = 1'b1; push("ram_served", ALL);
    cycles(4, "ram_hold");
    step(); idle_bus(); push("ram_end", ALL);

    // ROM read arriving just after the sample waits a full period
    wait_for(9);
    step();
    bus.cpu_addr = 16'h0000; bus.mreq_n = 1'b0; bus.rd_n = 1'b0;
    e_wait = 1'b0; e_rom = 1'b0;
    push("rom_late", ALL);
    cycles(21, "rom_wait");
    step(); e_wait = 1'b1; push("rom_served", ALL);
    step(); idle_bus(); push("rom_end", ALL);

    ga_write(8'h8C, 1'b0, 1'b0, "ga_8c");
    nchk++;
    if (lower_rom_en !== 1'b0 || upper_rom_en !== 1'b0) begin
      nfail++;
      $display("FAIL ga_8c_bits got=%b%b want=00", lower_rom_en, upper_rom_en);
    end
    peek(16'hC000, 1'b0, "peek_c000_ram");
    peek(16'h0000, 1'b0, "peek_0000_ram");
    ga_write(8'h40, 1'b0, 1'b0, "ga_40_nochange");
    ga_write(8'h84, 1'b0, 1'b1, "ga_84");
    peek(16'hC000, 1'b1, "peek_c000_rom");

    // IORQ and MREQ together: ignored
    wait_for(1);
    step();
    bus.cpu_addr = 16'h7F00; bus.mreq_n = 1'b0; bus.iorq_n = 1'b0;
    bus.wr_n = 1'b0; bus.data_from_cpu = 8'h80;
    push("io_mem_ignored", NO_WAIT);
    step(); push("io_mem_ignored", NO_WAIT);
    step(); idle_bus(); push("io_mem_end", ALL);

    ga_write(8'h80, 1'b1, 1'b1, "ga_80");
    nchk++;
    if (lower_rom_en !== 1'b1 || upper_rom_en !== 1'b1) begin
      nfail++;
      $display("FAIL ga_80_bits got=%b%b want=11", lower_rom_en, upper_rom_en);
    end
    peek(16'h0000, 1'b1, "peek_0000_rom");
    peek(16'h4000, 1'b0, "peek_4000_ram");

    // Memory write to a ROM-window address
    wait_for(6);
    step();
    bus.cpu_addr = 16'h0010; bus.mreq_n = 1'b0; bus.wr_n = 1'b0; e_wait = 1'b0;
    push("wr_req", ALL);
    cycles(4, "wr_wait");
    e_mwe = 1'b0;
    cycles(4, "wr_mwe");
    step(); e_mwe = 1'b1; e_wait = 1'b1; push("wr_served", ALL);
    step(); push("wr_hold", ALL);
    step(); idle_bus(); push("wr_end", ALL);
    cycles(16, "post_wr_idle");

    // Reset pulled in the middle of a write pulse
    wait_for(6);
    step();
    bus.cpu_addr = 16'h0010; bus.mreq_n = 1'b0; bus.wr_n = 1'b0; e_wait = 1'b0;
    push("rw_req", ALL);
    cycles(4, "rw_wait");
    step(); e_mwe = 1'b0; push("rw_mwe", ALL);
    step(); reset_n = 1'b0; idle_bus(); lo_e = 1'b1; up_e = 1'b1;
    push_raw("async_reset", ALL, RESET_VAL);
    #1;
    nchk++;
    if ({mwe_n, ras_n, cas_n} !== 3'b111) begin
      nfail++;
      $display("FAIL async_strobes got=%b want=111", {mwe_n, ras_n, cas_n});
    end
    repeat (2) begin step(); push_raw("reset_hold", ALL, RESET_VAL); end
    step(); reset_n = 1'b1; tph = 0;
    push("restart", ALL);
    cycles(31, "restart");

    step(); step();
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      nchk++; nfail++;
      $display("FAIL %s unchecked cyc=%0d got=none want=%b", cur.name, cur.cyc, cur.val);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout got=running want=finished");
    $fatal(1, "watchdog");
  end

endmodule
